// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter sharing the register-file write port between the pipeline and the multi-cycle unit.
// Define RF_WB_FWD_EN to add a read bypass from the registered write onto rd1_out/rd2_out.
module rf_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int CW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s0_valid,
  input  logic [AW-1:0]   s0_rd,
  input  logic [XLEN-1:0] s0_data,
  output logic            s0_ready,
  input  logic            s1_valid,
  input  logic [AW-1:0]   s1_rd,
  input  logic [XLEN-1:0] s1_data,
  output logic            s1_ready,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  input  logic [XLEN-1:0] rd1_in,
  input  logic [XLEN-1:0] rd2_in,
  output logic [XLEN-1:0] rd1_out,
  output logic [XLEN-1:0] rd2_out,
  output logic [CW-1:0]   conflict_cnt
);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  logic            r_prio;
  logic            r_we_p1;
  logic [AW-1:0]   r_waddr_p1;
  logic [XLEN-1:0] r_wdata_p1;
  logic [CW-1:0]   r_cnt;

  logic            w_contend;
  logic            w_grant0;
  logic            w_grant1;
  logic            w_xfer;
  logic [AW-1:0]   w_rd;
  logic [XLEN-1:0] w_data;

  // Stage p0: combinational grant; no grant is issued while reset is held
  always_comb begin
    w_contend = s0_valid && s1_valid;
    w_grant0  = 1'b0;
    w_grant1  = 1'b0;
    if (!rst) begin
      if (w_contend) begin
        w_grant0 = !r_prio;
        w_grant1 = r_prio;
      end else begin
        w_grant0 = s0_valid;
        w_grant1 = s1_valid;
      end
    end
    w_xfer = w_grant0 || w_grant1;
    w_rd   = w_grant1 ? s1_rd   : s0_rd;
    w_data = w_grant1 ? s1_data : s0_data;
  end

  assign s0_ready = w_grant0;
  assign s1_ready = w_grant1;

  // Stage p1: registered write toward the register file
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio     <= 1'b0;
      r_we_p1    <= 1'b0;
      r_waddr_p1 <= '0;
      r_wdata_p1 <= '0;
      r_cnt      <= '0;
    end else begin
      // After a contended grant the loser gets priority next time
      if (w_contend) begin
        r_prio <= w_grant0;
        r_cnt  <= sat_inc(r_cnt);
      end
      r_we_p1 <= w_xfer && (w_rd != '0);
      if (w_xfer) begin
        r_waddr_p1 <= w_rd;
        r_wdata_p1 <= w_data;
      end
    end
  end

  assign rf_we        = r_we_p1;
  assign rf_waddr     = r_waddr_p1;
  assign rf_wdata     = r_wdata_p1;
  assign conflict_cnt = r_cnt;

`ifdef RF_WB_FWD_EN
  function automatic logic [XLEN-1:0] fwd(input logic [AW-1:0] ra, input logic [XLEN-1:0] rd_in);
    return (r_we_p1 && ra == r_waddr_p1 && ra != '0) ? r_wdata_p1 : rd_in;
  endfunction

  assign rd1_out = fwd(ra1, rd1_in);
  assign rd2_out = fwd(ra2, rd2_in);
`else
  // Read addresses only matter to the bypass
  logic w_unused_ra;
  assign w_unused_ra = ^{ra1, ra2};
  assign rd1_out     = rd1_in;
  assign rd2_out     = rd2_in;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: expected writes are queued when stimulus is driven and popped after the next edge.
module tb_rf_wb_arbiter;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int CW   = 4;

  typedef struct packed {
    logic            we;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wb_t;

  logic            clk, rst;
  logic            s0_valid, s1_valid, s0_ready, s1_ready;
  logic [AW-1:0]   s0_rd, s1_rd, rf_waddr, ra1, ra2;
  logic [XLEN-1:0] s0_data, s1_data, rf_wdata, rd1_in, rd2_in, rd1_out, rd2_out;
  logic            rf_we;
  logic [CW-1:0]   conflict_cnt;

  logic [XLEN-1:0] tb_rf [32];
  logic            tb_clr;

  int n_checks = 0;
  int n_fail   = 0;

  wb_t             sb[$];
  logic            m_prio, m_we;
  logic [AW-1:0]   m_waddr;
  logic [XLEN-1:0] m_wdata;
  logic [CW-1:0]   m_cnt;
  logic            obs_g0, obs_g1;
  logic [XLEN-1:0] obs_rd1;

  rf_wb_arbiter #(.XLEN(XLEN), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_rd(s0_rd), .s0_data(s0_data), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_rd(s1_rd), .s1_data(s1_data), .s1_ready(s1_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ra1(ra1), .ra2(ra2), .rd1_in(rd1_in), .rd2_in(rd2_in),
    .rd1_out(rd1_out), .rd2_out(rd2_out), .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file the arbiter writes into
  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < 32; i++) tb_rf[i] <= (i == 0) ? 32'h0 : 32'h1000_0000 + i;
    end else if (rf_we && rf_waddr != '0) begin
      tb_rf[rf_waddr] <= rf_wdata;
    end
  end

  assign rd1_in = tb_rf[ra1];
  assign rd2_in = tb_rf[ra2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] ra);
`ifdef RF_WB_FWD_EN
    if (m_we && ra == m_waddr && ra != '0) return m_wdata;
`endif
    return tb_rf[ra];
  endfunction

  task automatic model_reset();
    m_prio = 1'b0; m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_cnt = '0;
    sb.delete();
  endtask

  // One clock cycle: drive at posedge+1, check grants at negedge, check the write after the next edge
  task automatic cycle(input logic v0, input logic [AW-1:0] a0, input logic [XLEN-1:0] d0,
                       input logic v1, input logic [AW-1:0] a1, input logic [XLEN-1:0] d1);
    logic g0, g1;
    wb_t  e;
    s0_valid = v0; s0_rd = a0; s0_data = d0;
    s1_valid = v1; s1_rd = a1; s1_data = d1;
    @(negedge clk);
    if (v0 && v1) begin
      g0 = !m_prio; g1 = m_prio;
    end else begin
      g0 = v0; g1 = v1;
    end
    check_eq("s0_ready", 32'(s0_ready), 32'(g0));
    check_eq("s1_ready", 32'(s1_ready), 32'(g1));
    check_eq("rd1_out", rd1_out, exp_rd(ra1));
    check_eq("rd2_out", rd2_out, exp_rd(ra2));
    obs_g0 = s0_ready; obs_g1 = s1_ready; obs_rd1 = rd1_out;
    e.we = 1'b0; e.addr = m_waddr; e.data = m_wdata;
    if (g0 || g1) begin
      e.addr = g1 ? a1 : a0;
      e.data = g1 ? d1 : d0;
      e.we   = (e.addr != '0);
    end
    sb.push_back(e);
    if (v0 && v1) begin
      m_prio = g0;
      if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
    end
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq("rf_we", 32'(rf_we), 32'(e.we));
    check_eq("rf_waddr", 32'(rf_waddr), 32'(e.addr));
    check_eq("rf_wdata", rf_wdata, e.data);
    check_eq("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
    m_we = e.we; m_waddr = e.addr; m_wdata = e.data;
  endtask

  task automatic idle();
    cycle(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    rst = 1'b0; tb_clr = 1'b1;
    s0_valid = 1'b0; s0_rd = '0; s0_data = '0;
    s1_valid = 1'b0; s1_rd = '0; s1_data = '0;
    ra1 = '0; ra2 = '0;
    #1 rst = 1'b1;
    s0_valid = 1'b1; s1_valid = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_s0_ready", 32'(s0_ready), 32'h0);
    check_eq("rst_s1_ready", 32'(s1_ready), 32'h0);
    check_eq("rst_rf_we", 32'(rf_we), 32'h0);
    check_eq("rst_waddr", 32'(rf_waddr), 32'h0);
    check_eq("rst_wdata", rf_wdata, 32'h0);
    check_eq("rst_cnt", 32'(conflict_cnt), 32'h0);
    s0_valid = 1'b0; s1_valid = 1'b0;
    @(posedge clk); #1;
    tb_clr = 1'b0; rst = 1'b0;
    model_reset();

    // Reset arriving after a transfer but before the edge that would register it
    s0_valid = 1'b1; s0_rd = 5'd3; s0_data = 32'hAAAA5555;
    @(negedge clk);
    check_eq("mid_s0_ready", 32'(s0_ready), 32'h1);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_ready0", 32'(s0_ready), 32'h0);
    check_eq("mid_ready1", 32'(s1_ready), 32'h0);
    s0_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_rf_we", 32'(rf_we), 32'h0);
    check_eq("mid_waddr", 32'(rf_waddr), 32'h0);
    check_eq("mid_wdata", rf_wdata, 32'h0);
    check_eq("mid_cnt", 32'(conflict_cnt), 32'h0);
    check_eq("mid_rd1_out", rd1_out, 32'h0);
    check_eq("mid_x3", tb_rf[3], 32'h1000_0003);
    rst = 1'b0;
    model_reset();

    // Single source
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    check_eq("single_ready", 32'(obs_g0), 32'h1);
    check_eq("single_we", 32'(rf_we), 32'h1);
    check_eq("single_waddr", 32'(rf_waddr), 32'd5);
    check_eq("single_wdata", rf_wdata, 32'hDEADBEEF);
    idle();
    check_eq("single_we_drop", 32'(rf_we), 32'h0);
    check_eq("single_x5", tb_rf[5], 32'hDEADBEEF);

    // Contention from reset
    rst = 1'b1; #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 5'd1, 32'h0000_00A1, 1'b1, 5'd2, 32'h0000_00B2);
      check_eq("cont_grant", 32'({obs_g0, obs_g1}), (i % 2 == 0) ? 32'h2 : 32'h1);
    end
    check_eq("cont_cnt", 32'(conflict_cnt), 32'd4);

    // Next contended grant goes to s0 (prio back at 0), then s1 alone keeps prio=1
    cycle(1'b1, 5'd10, 32'h0000_0010, 1'b1, 5'd11, 32'h0000_0011);
    check_eq("prio_after", 32'(obs_g0), 32'h1);
    cycle(1'b0, '0, '0, 1'b1, 5'd11, 32'h0000_0011);
    check_eq("uncontested_s1", 32'(obs_g1), 32'h1);

    // Same rd with prio=1: s1 first, s0 last
    cycle(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2);
    check_eq("same_rd_first", 32'(obs_g1), 32'h1);
    cycle(1'b1, 5'd7, 32'h1, 1'b0, '0, '0);
    check_eq("same_rd_second", 32'(obs_g0), 32'h1);
    idle();
    check_eq("same_rd_x7", tb_rf[7], 32'h1);

    // x0 drop
    cycle(1'b0, '0, '0, 1'b1, 5'd0, 32'h12345678);
    check_eq("x0_ready", 32'(obs_g1), 32'h1);
    check_eq("x0_we", 32'(rf_we), 32'h0);
    idle();

    // Read in the rf_we cycle of a write to x9
    cycle(1'b1, 5'd9, 32'hCAFEF00D, 1'b0, '0, '0);
    ra1 = 5'd9; ra2 = 5'd9;
    idle();
`ifdef RF_WB_FWD_EN
    check_eq("byp_rd1", obs_rd1, 32'hCAFEF00D);
`else
    check_eq("byp_rd1", obs_rd1, 32'h1000_0009);
`endif
    ra1 = '0; ra2 = '0;
    idle();

    // Counter saturation
    for (int i = 0; i < 16; i++) cycle(1'b1, 5'd12, 32'h0000_0C0C, 1'b1, 5'd13, 32'h0000_0D0D);
    check_eq("cnt_sat", 32'(conflict_cnt), 32'hF);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
